adquisicion_adc: RTL
====================

ADQUISICION_ADC -- requirements
Module: adquisicion_adc

Interface
REQ-001 Parameter SAMPLE_DIV, default 2268, SHALL set the clk cycles per sample period; legal range 40..65535.
REQ-002 Parameter SHIFT, default 8, SHALL set the left shift applied to the centred ADC code; legal range 0..12.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all logic is clocked on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: synchronous and active-high.
REQ-005 Port en, input, 1 bit, SHALL enable conversion starts.
REQ-006 Port sdata, input, 1 bit, SHALL carry serial ADC data, MSB first.
REQ-007 Port cs_n, output, 1 bit, SHALL be the active-low ADC chip select.
REQ-008 Port sclk, output, 1 bit, SHALL be the serial clock at clk/2 during a frame; idle high.
REQ-009 Port u, output, 25 bits, SHALL carry the signed two's-complement sample for the downstream filter.
REQ-010 Port rx, output, 1 bit, SHALL be a one-cycle strobe marking u as new.
REQ-011 Port busy, output, 1 bit, SHALL be high while a frame is in progress.

Function
REQ-012 A free-running period counter SHALL count 0..SAMPLE_DIV-1 and wrap; a start tick SHALL occur when count==0.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 IDLE->SHIFT SHALL occur on a start tick when en=1; the cycle after the tick SHALL have cs_n=0 and busy=1.
REQ-015 In SHIFT, sclk SHALL be 0 on the first cycle, then toggle every clk: 32 cycles give 16 rising edges.
REQ-016 sdata SHALL be registered into a 16-bit shift register on the clk edge where sclk goes 0->1.
REQ-017 After the 16th sampled bit, the FSM SHALL go to DONE with cs_n=1 and sclk=1.
REQ-018 In DONE, for exactly one cycle: u SHALL be loaded and rx=1. The FSM SHALL then return to IDLE with busy=0.
REQ-019 rx SHALL rise 34 cycles after the start tick cycle.
REQ-020 The data code d SHALL be shift-register bits [11:0]; the leading 4 bits SHALL be ignored.
REQ-021 u SHALL equal sign-extend(d - 2048) << SHIFT, computed in 25 bits, with no saturation needed within the legal SHIFT range.
REQ-022 u SHALL hold its value between DONE cycles.
REQ-023 rx SHALL be 0 in all states other than DONE.
REQ-024 Consecutive rx pulses SHALL be exactly SAMPLE_DIV cycles apart while en=1. This gives the 16+ cycle spacing the filter stage requires.
REQ-025 en falling mid-frame SHALL NOT abort the frame; the frame completes and produces rx.
REQ-026 No new frame SHALL start while en=0.
REQ-027 A start tick occurring while not IDLE SHALL be ignored; this cannot occur for legal SAMPLE_DIV.
REQ-028 The period counter SHALL run regardless of en.

Reset
REQ-029 When rst=1 at a clk edge, the following SHALL hold on the next cycle: state=IDLE, period counter=0, cs_n=1, sclk=1, rx=0, busy=0, u=0, shift register=0.
REQ-030 rst asserted mid-frame SHALL abort the frame with no rx pulse.
REQ-031 After rst deasserts with en=1, the first start tick SHALL occur on the first cycle with count==0.

Verification
REQ-032 Scenario 1: en=1, sdata word 0x0800 -> u=0, rx high for 1 cycle, 34 cycles after the tick.
REQ-033 Scenario 2: words 0x0FFF then 0x0000 -> u=25'h007FF00 (524032), then u=25'h1F80000 (-524288).
REQ-034 Scenario 3: word 0xF800 (nonzero leading bits) -> u=0, identical to 0x0800.
REQ-035 Scenario 4: SAMPLE_DIV=40, en=1 for 5 frames -> rx spacing exactly 40 cycles; cs_n low 32 cycles per frame; 16 sclk rising edges per frame.
REQ-036 Scenario 5: rst pulsed at SHIFT cycle 10 -> no rx, outputs at reset values, next frame decodes correctly.
REQ-037 Scenario 6: en dropped at SHIFT cycle 5 -> that frame still produces rx; no further cs_n activity until en=1.

Source files
------------

// File: rtl/adquisicion_adc_if.sv
// Serial ADC link plus the sample stream towards the filter stage.
// The acquisition block drives through the master modport. The ADC and the filter side use the slave modport.
interface adquisicion_adc_if;
   logic        en;
   logic        sdata;
   logic        cs_n;
   logic        sclk;
   logic [24:0] u;
   logic        rx;
   logic        busy;

   modport master (
      input  en, sdata,
      output cs_n, sclk, u, rx, busy
   );

   modport slave (
      output en, sdata,
      input  cs_n, sclk, u, rx, busy
   );
endinterface

// File: rtl/adquisicion_adc.sv
// Periodic 16-bit serial ADC reader. It frames one conversion per sample period.
// It recentres the 12-bit code and scales it into a signed 25-bit sample with a one-cycle strobe.
module adquisicion_adc #(
   parameter int unsigned SAMPLE_DIV = 2268,
   parameter int unsigned SHIFT      = 8
) (
   input  logic             clk,
   input  logic             rst,
   adquisicion_adc_if.master adc
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   localparam logic [15:0] CNT_MAX = 16'(SAMPLE_DIV - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  cyc_q, cyc_d;
   logic [15:0] sr_q, sr_d;
   logic [24:0] u_q, u_d;
   logic        cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        rx_q, rx_d;
   logic        busy_q, busy_d;

   logic              tick;
   logic signed [12:0] centred;
   logic signed [24:0] centred_ext;

   // The period counter never stops, so the sample rate is locked to clk even while en is low.
   always_comb begin
      cnt_d = (cnt_q == CNT_MAX) ? 16'd0 : cnt_q + 16'd1;
      tick  = (cnt_q == 16'd0);
   end

   always_comb begin
      centred     = 13'({1'b0, sr_q[11:0]}) - 13'sd2048;
      centred_ext = 25'(centred);
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      sr_d    = sr_q;
      u_d     = u_q;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      rx_d    = 1'b0;
      busy_d  = busy_q;
      unique case (state_q)
         S_IDLE: begin
            if (tick && adc.en) begin
               state_d = S_SHIFT;
               cyc_d   = 5'd0;
               cs_n_d  = 1'b0;
               sclk_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_SHIFT: begin
            sclk_d = ~sclk_q;
            cyc_d  = cyc_q + 5'd1;
            // The bit is captured on the same edge that raises sclk toward the ADC.
            if (!sclk_q)
               sr_d = {sr_q[14:0], adc.sdata};
            if (cyc_q == 5'd31) begin
               state_d = S_DONE;
               cs_n_d  = 1'b1;
               sclk_d  = 1'b1;
            end
         end
         S_DONE: begin
            u_d     = centred_ext <<< SHIFT;
            rx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         cyc_q   <= 5'd0;
         sr_q    <= 16'd0;
         u_q     <= 25'd0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b1;
         rx_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         sr_q    <= sr_d;
         u_q     <= u_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         rx_q    <= rx_d;
         busy_q  <= busy_d;
      end
   end

   assign adc.cs_n = cs_n_q;
   assign adc.sclk = sclk_q;
   assign adc.u    = u_q;
   assign adc.rx   = rx_q;
   assign adc.busy = busy_q;

endmodule
